// File: rtl/clock_sched_pkg.sv
// rtl/clock_sched_pkg.sv - shared FSM state encoding and default sizing for the target clock scheduler
package clock_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } sched_state_e;

    localparam int DEFAULT_NUM_CLOCKS = 2;
    localparam int DEFAULT_ACC_W      = 16;

endpackage

// File: rtl/phase_accumulator.sv
// rtl/phase_accumulator.sv - one target clock's phase accumulator producing a registered clock enable
module phase_accumulator
    import clock_sched_pkg::*;
#(
    parameter int ACC_W = DEFAULT_ACC_W
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             advance,
    input  logic [ACC_W:0]   inc,
    output logic             ce
);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic             ce_q, ce_d;
    logic [ACC_W:0]   sum;
    logic             full_rate;

    // An increment of one full turn or more fires every cycle and leaves the phase alone.
    always_comb begin
        sum       = {1'b0, acc_q} + inc;
        full_rate = inc[ACC_W];
        acc_d     = acc_q;
        ce_d      = 1'b0;
        if (advance) begin
            if (full_rate) begin
                ce_d = 1'b1;
            end else begin
                ce_d  = sum[ACC_W];
                acc_d = sum[ACC_W-1:0];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            acc_q <= '0;
            ce_q  <= 1'b0;
        end else begin
            acc_q <= acc_d;
            ce_q  <= ce_d;
        end
    end

    assign ce = ce_q;

endmodule

// File: rtl/target_clock_scheduler.sv
// rtl/target_clock_scheduler.sv - runs N base cycles of phase-accumulated target clock enables; SCHED_CYCLE_COUNT_EN adds fired_count
module target_clock_scheduler
    import clock_sched_pkg::*;
#(
    parameter int NUM_CLOCKS = DEFAULT_NUM_CLOCKS,
    parameter int ACC_W      = DEFAULT_ACC_W
) (
    input  logic                             clock,
    input  logic                             reset_n,
    input  logic                             step_valid,
    output logic                             step_ready,
    input  logic [31:0]                      step_count,
    input  logic [NUM_CLOCKS*(ACC_W+1)-1:0]  inc,
    input  logic                             stall,
    output logic [NUM_CLOCKS-1:0]            ce,
    output logic                             done,
    output logic                             busy
`ifdef SCHED_CYCLE_COUNT_EN
    ,
    output logic [NUM_CLOCKS*64-1:0]         fired_count
`endif
);

    localparam int INC_W = NUM_CLOCKS * (ACC_W + 1);

    sched_state_e     state_q, state_d;
    logic [31:0]      remaining_q, remaining_d;
    logic [INC_W-1:0] inc_q, inc_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             ready_q, ready_d;
    logic             advance;

    assign advance = (state_q == ST_RUN) && !stall;

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        inc_d       = inc_q;
        case (state_q)
            ST_IDLE: begin
                if (step_valid) begin
                    remaining_d = step_count;
                    inc_d       = inc;
                    state_d     = (step_count == 32'd0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (!stall) begin
                    remaining_d = remaining_q - 32'd1;
                    if (remaining_q == 32'd1) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        busy_d  = (state_d == ST_RUN);
        done_d  = (state_d == ST_DONE);
        ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            inc_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            inc_q       <= inc_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            ready_q     <= ready_d;
        end
    end

    assign step_ready = ready_q;
    assign busy       = busy_q;
    assign done       = done_q;

    for (genvar g = 0; g < NUM_CLOCKS; g++) begin : g_acc
        phase_accumulator #(
            .ACC_W(ACC_W)
        ) u_acc (
            .clock  (clock),
            .reset_n(reset_n),
            .advance(advance),
            .inc    (inc_q[g*(ACC_W+1) +: (ACC_W+1)]),
            .ce     (ce[g])
        );
    end

`ifdef SCHED_CYCLE_COUNT_EN
    for (genvar g = 0; g < NUM_CLOCKS; g++) begin : g_cnt
        logic [63:0] fired_count_q, fired_count_d;

        always_comb fired_count_d = fired_count_q + 64'(ce[g]);

        always_ff @(posedge clock) begin
            if (!reset_n) begin
                fired_count_q <= '0;
            end else begin
                fired_count_q <= fired_count_d;
            end
        end

        assign fired_count[g*64 +: 64] = fired_count_q;
    end
`endif

endmodule

// File: tb/tb_target_clock_scheduler.sv
// tb/tb_target_clock_scheduler.sv - scoreboard bench for target_clock_scheduler
module tb_target_clock_scheduler;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        step_valid;
    logic        step_ready;
    logic [31:0] step_count;
    logic [33:0] inc;
    logic        stall;
    logic [1:0]  ce;
    logic        done;
    logic        busy;
`ifdef SCHED_CYCLE_COUNT_EN
    logic [127:0] fired_count;
`endif

    target_clock_scheduler #(
        .NUM_CLOCKS(2),
        .ACC_W     (16)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .step_valid(step_valid),
        .step_ready(step_ready),
        .step_count(step_count),
        .inc       (inc),
        .stall     (stall),
        .ce        (ce),
        .done      (done),
        .busy      (busy)
`ifdef SCHED_CYCLE_COUNT_EN
        ,
        .fired_count(fired_count)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        int         cyc;
        logic [1:0] val;
    } ce_exp_t;

    ce_exp_t exp_ce_q[$];
    int      exp_done_q[$];
    int      cyc = 0;
    int      checks = 0;
    int      failures = 0;
    bit      mon_en = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every ce or done pulse must match the next expected entry.
    always @(negedge clock) begin
        if (mon_en) begin
            if (ce != 2'b00) begin
                if (exp_ce_q.size() == 0) begin
                    chk("ce_unexpected", {126'd0, ce}, 128'd0);
                end else begin
                    ce_exp_t e;
                    e = exp_ce_q.pop_front();
                    chk("ce_cycle", cyc, e.cyc);
                    chk("ce_value", {126'd0, ce}, {126'd0, e.val});
                end
            end
            if (done) begin
                if (exp_done_q.size() == 0) begin
                    chk("done_unexpected", {127'd0, done}, 128'd0);
                end else begin
                    chk("done_cycle", cyc, exp_done_q.pop_front());
                end
            end
        end
    end

    task automatic push_ce(input int c, input logic [1:0] v);
        ce_exp_t e;
        e.cyc = c;
        e.val = v;
        exp_ce_q.push_back(e);
    endtask

    // Called just after a negedge; acceptance happens at the next rising edge.
    task automatic run(input int n, input logic [16:0] i0, input logic [16:0] i1,
                       input logic [15:0] stall_mask, input int ncyc);
        step_valid = 1'b1;
        step_count = n;
        inc        = {i1, i0};
        @(negedge clock);
        step_valid = 1'b0;
        inc        = '1;
        chk("busy_after_accept", {127'd0, busy}, {127'd0, (n > 0)});
        chk("ready_after_accept", {127'd0, step_ready}, 128'd0);
        for (int r = 1; r <= ncyc; r++) begin
            stall = stall_mask[r];
            @(negedge clock);
        end
        stall = 1'b0;
        chk("ready_after_run", {127'd0, step_ready}, 128'd1);
    endtask

    initial begin
        int a;
        reset_n    = 1'b0;
        step_valid = 1'b0;
        step_count = '0;
        inc        = '0;
        stall      = 1'b0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        chk("reset_ce", {126'd0, ce}, 128'd0);
        chk("reset_done", {127'd0, done}, 128'd0);
        chk("reset_busy", {127'd0, busy}, 128'd0);
        chk("reset_ready", {127'd0, step_ready}, 128'd1);
        mon_en = 1'b1;

        // Half rate on clock 0: 0,1,0,1,... over 8 cycles
        a = cyc + 1;
        for (int k = 2; k <= 8; k += 2) push_ce(a + k, 2'b01);
        exp_done_q.push_back(a + 8);
        run(8, 17'h08000, 17'h00000, 16'h0000, 9);

        // Full rate on clock 1 with RUN cycles 2-3 stalled
        a = cyc + 1;
        push_ce(a + 1, 2'b10);
        for (int k = 4; k <= 7; k++) push_ce(a + k, 2'b10);
        exp_done_q.push_back(a + 7);
        run(5, 17'h00000, 17'h10000, 16'b0000_0000_0000_1100, 8);

        // Zero-length run: done only
        a = cyc + 1;
        exp_done_q.push_back(a);
        run(0, 17'h08000, 17'h08000, 16'h0000, 1);

        // Leave clock 0 phase at half a turn
        a = cyc + 1;
        exp_done_q.push_back(a + 1);
        run(1, 17'h08000, 17'h00000, 16'h0000, 2);

        // 0x5555 from 0x8000 over two 3-cycle runs: one carry in each
        a = cyc + 1;
        push_ce(a + 2, 2'b01);
        exp_done_q.push_back(a + 3);
        run(3, 17'h05555, 17'h00000, 16'h0000, 4);
        a = cyc + 1;
        push_ce(a + 2, 2'b01);
        exp_done_q.push_back(a + 3);
        run(3, 17'h05555, 17'h00000, 16'h0000, 4);

        // Reset on the 3rd RUN cycle of a 10-cycle run
        a = cyc + 1;
        push_ce(a + 1, 2'b10);
        push_ce(a + 2, 2'b10);
        step_valid = 1'b1;
        step_count = 32'd10;
        inc        = {17'h10000, 17'h00000};
        @(negedge clock);
        step_valid = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        chk("mid_reset_ce", {126'd0, ce}, 128'd0);
        chk("mid_reset_busy", {127'd0, busy}, 128'd0);
        chk("mid_reset_done", {127'd0, done}, 128'd0);
        reset_n = 1'b1;
        @(negedge clock);
        chk("post_reset_ready", {127'd0, step_ready}, 128'd1);
`ifdef SCHED_CYCLE_COUNT_EN
        chk("post_reset_fired_count", fired_count, 128'd0);
`endif
        repeat (3) @(negedge clock);

        // Reset cleared phase: 0x8002 from zero must not carry
        a = cyc + 1;
        exp_done_q.push_back(a + 1);
        run(1, 17'h08002, 17'h00000, 16'h0000, 2);

        repeat (2) @(negedge clock);
        chk("ce_pulses_missing", exp_ce_q.size(), 128'd0);
        chk("done_pulses_missing", exp_done_q.size(), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
